// File: rtl/gpio_multibank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_multibank_if : IP-side register port of the multibank GPIO core |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface gpio_multibank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] i_ip_address;
  logic                  i_ip_read_en;
  logic                  i_ip_write_en;
  logic [DATA_WIDTH-1:0] i_ip_wdata;
  logic [DATA_WIDTH-1:0] o_ip_rdata;
  logic                  o_ip_ack;
  logic                  o_ip_stall;

  modport master (
    output i_ip_address, i_ip_read_en, i_ip_write_en, i_ip_wdata,
    input  o_ip_rdata, o_ip_ack, o_ip_stall
  );

  modport slave (
    input  i_ip_address, i_ip_read_en, i_ip_write_en, i_ip_wdata,
    output o_ip_rdata, o_ip_ack, o_ip_stall
  );
endinterface
`default_nettype wire

// File: rtl/gpio_multibank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_multibank : banked GPIO with atomic writes, debounce and IRQs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_multibank #(
  parameter int           WB_REGISTER_ADDRESS_WIDTH   = 16,
  parameter int           WB_DATA_WIDTH               = 32,
  parameter int           NUM_PINS                    = 64,
  parameter int           DEBOUNCE_WIDTH              = 16,
  parameter logic [127:0] DEFAULT_GPIO_DIRECTION_FULL = {128{1'b1}},
  parameter logic [127:0] DEFAULT_GPIO_OUTPUT_FULL    = '0
) (
  input  wire logic                i_clk,
  input  wire logic                i_reset,
  gpio_multibank_if.slave          bus,
  input  wire logic [NUM_PINS-1:0] i_gpio_in,
  output logic      [NUM_PINS-1:0] o_gpio_out,
  output logic      [NUM_PINS-1:0] o_gpio_oe,
  output logic                     o_irq
);

  localparam int c_AW        = WB_REGISTER_ADDRESS_WIDTH;
  localparam int c_DW        = WB_DATA_WIDTH;
  localparam int c_NUM_BANKS = (NUM_PINS + c_DW - 1) / c_DW;
  localparam int c_TOT_W     = c_NUM_BANKS * c_DW;
  localparam int c_BANK_W    = c_AW - 6;

  localparam logic [3:0] c_REG_DIR      = 4'h0;
  localparam logic [3:0] c_REG_OUT      = 4'h1;
  localparam logic [3:0] c_REG_OUT_SET  = 4'h2;
  localparam logic [3:0] c_REG_OUT_CLR  = 4'h3;
  localparam logic [3:0] c_REG_OUT_TGL  = 4'h4;
  localparam logic [3:0] c_REG_IN       = 4'h5;
  localparam logic [3:0] c_REG_IRQ_EN   = 4'h6;
  localparam logic [3:0] c_REG_IRQ_TYPE = 4'h7;
  localparam logic [3:0] c_REG_IRQ_POL  = 4'h8;
  localparam logic [3:0] c_REG_IRQ_BOTH = 4'h9;
  localparam logic [3:0] c_REG_IRQ_STAT = 4'hA;
  localparam logic [3:0] c_REG_DEBOUNCE = 4'hB;

  // Programmable state
  logic [NUM_PINS-1:0]       r_dir;
  logic [NUM_PINS-1:0]       r_out;
  logic [NUM_PINS-1:0]       r_irq_en;
  logic [NUM_PINS-1:0]       r_irq_type;
  logic [NUM_PINS-1:0]       r_irq_pol;
  logic [NUM_PINS-1:0]       r_irq_both;
  logic [NUM_PINS-1:0]       r_irq_status;
  logic [DEBOUNCE_WIDTH-1:0] r_debounce;

  // Input path
  logic [NUM_PINS-1:0]       r_sync1;
  logic [NUM_PINS-1:0]       r_sync2;
  logic [NUM_PINS-1:0]       r_tick_samp;
  logic [NUM_PINS-1:0]       r_in;
  logic [NUM_PINS-1:0]       r_in_d;
  logic [DEBOUNCE_WIDTH-1:0] r_prescale;

  // Bus response
  logic                      r_ack;
  logic [c_DW-1:0]           r_rdata;

  // Address decode
  logic [c_BANK_W-1:0]       w_bank;
  logic [3:0]                w_reg;
  logic [c_NUM_BANKS-1:0]    w_sel;
  logic                      w_bank_ok;
  logic                      w_wr;
  logic [c_TOT_W-1:0]        w_mask_full;
  logic [c_TOT_W-1:0]        w_wdata_full;
  logic [NUM_PINS-1:0]       w_mask;
  logic [NUM_PINS-1:0]       w_wbits;
  logic [NUM_PINS-1:0]       w_w1c;

  assign w_bank    = bus.i_ip_address[c_AW-1:6];
  assign w_reg     = bus.i_ip_address[5:2];
  assign w_bank_ok = |w_sel;
  assign w_wr      = bus.i_ip_write_en && w_bank_ok;

  always_comb begin
    w_sel = '0;
    for (int b = 0; b < c_NUM_BANKS; b++) begin
      w_sel[b] = (w_bank == c_BANK_W'(b));
    end
  end

  // Replicating the write word across banks and masking by the selected bank
  // turns every banked write into a plain full-width read-modify-write.
  for (genvar b = 0; b < c_NUM_BANKS; b++) begin : g_mask
    assign w_mask_full[b*c_DW +: c_DW] = {c_DW{w_sel[b]}};
  end

  assign w_wdata_full = {c_NUM_BANKS{bus.i_ip_wdata}};
  assign w_mask       = w_mask_full[NUM_PINS-1:0];
  assign w_wbits      = w_wdata_full[NUM_PINS-1:0] & w_mask;
  assign w_w1c        = (w_wr && (w_reg == c_REG_IRQ_STAT)) ? w_wbits : '0;

  // Debounce prescaler and filter
  logic                w_bypass;
  logic                w_tick;
  logic [NUM_PINS-1:0] w_stable;

  assign w_bypass = (r_debounce == '0);
  assign w_tick   = !w_bypass && (r_prescale >= r_debounce);
  assign w_stable = ~(r_sync2 ^ r_tick_samp);

  // Interrupt events, evaluated on the filtered input
  logic [NUM_PINS-1:0] w_rise;
  logic [NUM_PINS-1:0] w_fall;
  logic [NUM_PINS-1:0] w_edge_ev;
  logic [NUM_PINS-1:0] w_level_ev;
  logic [NUM_PINS-1:0] w_event;

  assign w_rise     = r_in & ~r_in_d;
  assign w_fall     = ~r_in & r_in_d;
  assign w_edge_ev  = (r_irq_both & (w_rise | w_fall))
                    | (~r_irq_both & ~r_irq_pol & w_rise)
                    | (~r_irq_both &  r_irq_pol & w_fall);
  assign w_level_ev = (r_irq_pol & r_in) | (~r_irq_pol & ~r_in);
  assign w_event    = (r_irq_type & w_level_ev) | (~r_irq_type & w_edge_ev);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dir        <= DEFAULT_GPIO_DIRECTION_FULL[NUM_PINS-1:0];
      r_out        <= DEFAULT_GPIO_OUTPUT_FULL[NUM_PINS-1:0];
      r_irq_en     <= '0;
      r_irq_type   <= '0;
      r_irq_pol    <= '0;
      r_irq_both   <= '0;
      r_debounce   <= '0;
    end else if (w_wr) begin
      case (w_reg)
        c_REG_DIR:      r_dir      <= (r_dir & ~w_mask) | w_wbits;
        c_REG_OUT:      r_out      <= (r_out & ~w_mask) | w_wbits;
        c_REG_OUT_SET:  r_out      <= r_out | w_wbits;
        c_REG_OUT_CLR:  r_out      <= r_out & ~w_wbits;
        c_REG_OUT_TGL:  r_out      <= r_out ^ w_wbits;
        c_REG_IRQ_EN:   r_irq_en   <= (r_irq_en & ~w_mask) | w_wbits;
        c_REG_IRQ_TYPE: r_irq_type <= (r_irq_type & ~w_mask) | w_wbits;
        c_REG_IRQ_POL:  r_irq_pol  <= (r_irq_pol & ~w_mask) | w_wbits;
        c_REG_IRQ_BOTH: r_irq_both <= (r_irq_both & ~w_mask) | w_wbits;
        c_REG_DEBOUNCE: begin
          if (w_sel[0]) begin
            r_debounce <= bus.i_ip_wdata[DEBOUNCE_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // A new event on the same bit as a W1C wins, so an active level keeps STATUS set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_w1c) | (w_event & r_irq_en);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_tick_samp <= '0;
      r_in        <= '0;
      r_in_d      <= '0;
      r_prescale  <= '0;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      r_in_d  <= r_in;
      if (w_bypass || w_tick) begin
        r_prescale <= '0;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end
      if (w_bypass) begin
        r_in        <= r_sync2;
        r_tick_samp <= r_sync2;
      end else if (w_tick) begin
        r_in        <= (r_in & ~w_stable) | (r_sync2 & w_stable);
        r_tick_samp <= r_sync2;
      end
    end
  end

  // Read mux; bits beyond NUM_PINS come from the zero padding
  logic [c_TOT_W-1:0] w_dir_pad;
  logic [c_TOT_W-1:0] w_out_pad;
  logic [c_TOT_W-1:0] w_in_pad;
  logic [c_TOT_W-1:0] w_en_pad;
  logic [c_TOT_W-1:0] w_type_pad;
  logic [c_TOT_W-1:0] w_pol_pad;
  logic [c_TOT_W-1:0] w_both_pad;
  logic [c_TOT_W-1:0] w_stat_pad;
  logic [c_DW-1:0]    w_rd_word;

  assign w_dir_pad  = c_TOT_W'(r_dir);
  assign w_out_pad  = c_TOT_W'(r_out);
  assign w_in_pad   = c_TOT_W'(r_in);
  assign w_en_pad   = c_TOT_W'(r_irq_en);
  assign w_type_pad = c_TOT_W'(r_irq_type);
  assign w_pol_pad  = c_TOT_W'(r_irq_pol);
  assign w_both_pad = c_TOT_W'(r_irq_both);
  assign w_stat_pad = c_TOT_W'(r_irq_status);

  always_comb begin
    w_rd_word = '0;
    for (int b = 0; b < c_NUM_BANKS; b++) begin
      if (w_sel[b]) begin
        case (w_reg)
          c_REG_DIR:      w_rd_word = w_dir_pad[b*c_DW +: c_DW];
          c_REG_OUT:      w_rd_word = w_out_pad[b*c_DW +: c_DW];
          c_REG_IN:       w_rd_word = w_in_pad[b*c_DW +: c_DW];
          c_REG_IRQ_EN:   w_rd_word = w_en_pad[b*c_DW +: c_DW];
          c_REG_IRQ_TYPE: w_rd_word = w_type_pad[b*c_DW +: c_DW];
          c_REG_IRQ_POL:  w_rd_word = w_pol_pad[b*c_DW +: c_DW];
          c_REG_IRQ_BOTH: w_rd_word = w_both_pad[b*c_DW +: c_DW];
          c_REG_IRQ_STAT: w_rd_word = w_stat_pad[b*c_DW +: c_DW];
          c_REG_DEBOUNCE: begin
            if (b == 0) begin
              w_rd_word = c_DW'(r_debounce);
            end
          end
          default: w_rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus.i_ip_read_en || bus.i_ip_write_en;
      r_rdata <= bus.i_ip_read_en ? w_rd_word : '0;
    end
  end

  assign bus.o_ip_ack   = r_ack;
  assign bus.o_ip_rdata = r_rdata;
  assign bus.o_ip_stall = 1'b0;
  assign o_gpio_out     = r_out;
  assign o_gpio_oe      = r_dir;
  assign o_irq          = |(r_irq_status & r_irq_en);

  logic w_unused;
  assign w_unused = ^{bus.i_ip_address[1:0], w_mask_full, w_wdata_full};

endmodule
`default_nettype wire

// File: tb/tb_gpio_multibank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_multibank : self-checking bench for gpio_multibank (40 pins) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gpio_multibank;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int NP  = 40;
  localparam int NB  = (NP + DW - 1) / DW;
  localparam int DBW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [NP-1:0] i_gpio_in;
  logic [NP-1:0] o_gpio_out;
  logic [NP-1:0] o_gpio_oe;
  logic          o_irq;

  gpio_multibank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpio_multibank #(
    .WB_REGISTER_ADDRESS_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .NUM_PINS(NP),
    .DEBOUNCE_WIDTH(DBW)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus),
    .i_gpio_in(i_gpio_in),
    .o_gpio_out(o_gpio_out),
    .o_gpio_oe(o_gpio_oe),
    .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Register-level reference model, one bit per pin
  bit             m_dir  [NP];
  bit             m_out  [NP];
  bit             m_en   [NP];
  bit             m_typ  [NP];
  bit             m_pol  [NP];
  bit             m_both [NP];
  bit             m_stat [NP];
  logic [DBW-1:0] m_deb;

  function automatic void m_reset();
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = 1'b1; m_out[p] = 1'b0; m_en[p] = 1'b0; m_typ[p] = 1'b0;
      m_pol[p] = 1'b0; m_both[p] = 1'b0; m_stat[p] = 1'b0;
    end
    m_deb = '0;
  endfunction

  function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int bank = int'(a >> 6);
    int r    = int'((a >> 2) & 16'hF);
    if (bank >= NB) return;
    if (r == 11 && bank == 0) m_deb = d[DBW-1:0];
    for (int i = 0; i < DW; i++) begin
      int p = bank * DW + i;
      if (p < NP) begin
        case (r)
          0:  m_dir[p]  = d[i];
          1:  m_out[p]  = d[i];
          2:  if (d[i]) m_out[p] = 1'b1;
          3:  if (d[i]) m_out[p] = 1'b0;
          4:  if (d[i]) m_out[p] = !m_out[p];
          6:  m_en[p]   = d[i];
          7:  m_typ[p]  = d[i];
          8:  m_pol[p]  = d[i];
          9:  m_both[p] = d[i];
          10: if (d[i]) m_stat[p] = 1'b0;
          default: ;
        endcase
      end
    end
  endfunction

  // IN reads as zero while the model is used because the pads are held low.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v = '0;
    int bank = int'(a >> 6);
    int r    = int'((a >> 2) & 16'hF);
    if (bank >= NB) return v;
    if (r == 11 && bank == 0) return DW'(m_deb);
    for (int i = 0; i < DW; i++) begin
      int p = bank * DW + i;
      if (p < NP) begin
        case (r)
          0:  v[i] = m_dir[p];
          1:  v[i] = m_out[p];
          6:  v[i] = m_en[p];
          7:  v[i] = m_typ[p];
          8:  v[i] = m_pol[p];
          9:  v[i] = m_both[p];
          10: v[i] = m_stat[p];
          default: ;
        endcase
      end
    end
    return v;
  endfunction

  function automatic logic [NP-1:0] m_outvec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = m_out[p];
    return v;
  endfunction

  function automatic logic [NP-1:0] m_dirvec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = m_dir[p];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_access(input bit wr_n_rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    @(negedge i_clk);
    check("ack_idle", 64'(bus.o_ip_ack), 64'(0));
    bus.i_ip_address  = a;
    bus.i_ip_wdata    = wd;
    bus.i_ip_write_en = wr_n_rd;
    bus.i_ip_read_en  = !wr_n_rd;
    @(negedge i_clk);
    bus.i_ip_write_en = 1'b0;
    bus.i_ip_read_en  = 1'b0;
    check("ack", 64'(bus.o_ip_ack), 64'(1));
    rd = bus.o_ip_rdata;
    if (wr_n_rd) m_write(a, wd);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] dummy;
    bus_access(1'b1, a, d, dummy);
  endtask

  task automatic rd_exp(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] r;
    bus_access(1'b0, a, '0, r);
    check(tag, 64'(r), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_irq = 0;
    i_reset = 1'b1;
    i_gpio_in = '0;
    bus.i_ip_address = '0;
    bus.i_ip_wdata = '0;
    bus.i_ip_read_en = 1'b0;
    bus.i_ip_write_en = 1'b0;
    m_reset();
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    // Reset state
    check("rst_oe", 64'(o_gpio_oe), 64'(40'hFF_FFFF_FFFF));
    check("rst_out", 64'(o_gpio_out), 64'(0));
    check("rst_irq", 64'(o_irq), 64'(0));
    check("rst_rdata", 64'(bus.o_ip_rdata), 64'(0));
    check("rst_stall", 64'(bus.o_ip_stall), 64'(0));
    rd_exp("rst_dir0", 16'h0000, 32'hFFFF_FFFF);
    rd_exp("rst_out0", 16'h0004, 32'h0);
    rd_exp("rst_dir1", 16'h0040, 32'h0000_00FF);

    // Randomized register traffic against the model (IRQ_EN left clear)
    for (int it = 0; it < 80; it++) begin
      int bk;
      int rg;
      bit w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bk = int'($urandom_range(0, 3));
      rg = int'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      if (rg == 6) rg = 1;
      a = AW'(bk * 64 + rg * 4);
      d = $urandom;
      if (w) wr(a, d);
      else rd_exp("rand_rd", a, m_read(a));
      check("rand_out", 64'(o_gpio_out), 64'(m_outvec()));
      check("rand_oe", 64'(o_gpio_oe), 64'(m_dirvec()));
    end

    // Atomic output writes
    wr(16'h0004, 32'h0000_00F0);
    check("out_wr_next", 64'(o_gpio_out[31:0]), 64'(32'hF0));
    wr(16'h0008, 32'h1);
    wr(16'h000C, 32'h10);
    wr(16'h0010, 32'h3);
    rd_exp("out_atomic", 16'h0004, 32'h0000_00E2);
    check("out_pins", 64'(o_gpio_out[31:0]), 64'(32'hE2));
    check("out_model", 64'(o_gpio_out), 64'(m_outvec()));
    rd_exp("set_reads0", 16'h0008, 32'h0);

    // Quiet interrupt configuration on both banks
    wr(16'h002C, 32'h0);
    wr(16'h001C, 32'h0); wr(16'h0020, 32'h0); wr(16'h0024, 32'h0);
    wr(16'h005C, 32'h0); wr(16'h0060, 32'h0); wr(16'h0064, 32'h0);
    wr(16'h0028, 32'hFFFF_FFFF); wr(16'h0068, 32'hFFFF_FFFF);

    // Rising edge on pin 5, no debounce: o_irq at k+3
    wr(16'h0018, 32'h20);
    @(negedge i_clk); i_gpio_in[5] = 1'b1;
    repeat (3) @(negedge i_clk);
    check("irq_k2", 64'(o_irq), 64'(0));
    @(negedge i_clk);
    check("irq_k3", 64'(o_irq), 64'(1));
    rd_exp("stat_rise", 16'h0028, 32'h20);
    wr(16'h0028, 32'h20);
    check("irq_w1c", 64'(o_irq), 64'(0));
    rd_exp("stat_cleared", 16'h0028, 32'h0);

    // Level-high on pin 3
    wr(16'h0018, 32'h0);
    wr(16'h001C, 32'h08);
    wr(16'h0020, 32'h08);
    wr(16'h0018, 32'h08);
    @(negedge i_clk); i_gpio_in[3] = 1'b1;
    repeat (4) @(negedge i_clk);
    rd_exp("lvl_set", 16'h0028, 32'h08);
    wr(16'h0028, 32'h08);
    @(negedge i_clk);
    rd_exp("lvl_reset", 16'h0028, 32'h08);
    check("lvl_irq", 64'(o_irq), 64'(1));
    i_gpio_in[3] = 1'b0;
    repeat (4) @(negedge i_clk);
    wr(16'h0028, 32'h08);
    rd_exp("lvl_clr", 16'h0028, 32'h0);
    check("lvl_irq_off", 64'(o_irq), 64'(0));

    // Rising-edge event on pin 3 coincident with a W1C of the same bit
    wr(16'h001C, 32'h0);
    wr(16'h0020, 32'h0);
    @(negedge i_clk); i_gpio_in[3] = 1'b1;
    repeat (2) @(negedge i_clk);
    wr(16'h0028, 32'h08);
    rd_exp("set_wins", 16'h0028, 32'h08);

    wr(16'h0018, 32'h0);
    i_gpio_in = '0;
    repeat (5) @(negedge i_clk);
    wr(16'h0028, 32'hFFFF_FFFF);
    rd_exp("in_idle", 16'h0014, 32'h0);

    // Debounce = 4: glitch rejected, held level accepted in two ticks
    wr(16'h002C, 32'h4);
    rd_exp("deb_rd", 16'h002C, 32'h4);
    wr(16'h0024, 32'h1);
    wr(16'h0018, 32'h1);
    @(negedge i_clk); i_gpio_in[0] = 1'b1;
    repeat (3) @(negedge i_clk);
    i_gpio_in[0] = 1'b0;
    repeat (20) @(negedge i_clk);
    check("glitch_irq", 64'(o_irq), 64'(0));
    rd_exp("glitch_in", 16'h0014, 32'h0);
    @(negedge i_clk); i_gpio_in[0] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge i_clk);
      if (c == 8) check("deb_early", 64'(o_irq), 64'(0));
    end
    check("deb_late", 64'(o_irq), 64'(1));
    rd_exp("deb_in", 16'h0014, 32'h1);
    wr(16'h0018, 32'h0);
    wr(16'h0024, 32'h0);
    wr(16'h002C, 32'h0);
    i_gpio_in[0] = 1'b0;
    repeat (4) @(negedge i_clk);
    wr(16'h0028, 32'hFFFF_FFFF);
    check("deb_irq_off", 64'(o_irq), 64'(0));

    // Both-edge on pin 35 (bank 1 bit 3)
    wr(16'h0064, 32'h08);
    wr(16'h0058, 32'h08);
    @(negedge i_clk); i_gpio_in[35] = 1'b1;
    repeat (4) @(negedge i_clk);
    if (o_irq) n_irq++;
    rd_exp("both_1", 16'h0068, 32'h08);
    wr(16'h0068, 32'h08);
    rd_exp("both_clr", 16'h0068, 32'h0);
    @(negedge i_clk); i_gpio_in[35] = 1'b0;
    repeat (4) @(negedge i_clk);
    if (o_irq) n_irq++;
    rd_exp("both_2", 16'h0068, 32'h08);
    check("both_count", 64'(n_irq), 64'(2));
    wr(16'h0068, 32'h08);
    wr(16'h0058, 32'h0);
    check("both_irq_off", 64'(o_irq), 64'(0));

    // Out-of-range bank and unmapped offsets
    rd_exp("unmapped_rd", 16'h0080, 32'h0);
    wr(16'h0080, 32'hFFFF_FFFF);
    wr(16'h0030, 32'hFFFF_FFFF);
    check("unmapped_out", 64'(o_gpio_out), 64'(m_outvec()));
    check("unmapped_oe", 64'(o_gpio_oe), 64'(m_dirvec()));
    rd_exp("unmapped_rd30", 16'h0030, 32'h0);
    rd_exp("dir_after", 16'h0000, m_read(16'h0000));

    // Back-to-back reads
    @(negedge i_clk);
    bus.i_ip_address = 16'h0000; bus.i_ip_read_en = 1'b1;
    @(negedge i_clk);
    check("b2b_ack0", 64'(bus.o_ip_ack), 64'(1));
    check("b2b_rd0", 64'(bus.o_ip_rdata), 64'(m_read(16'h0000)));
    bus.i_ip_address = 16'h0044;
    @(negedge i_clk);
    bus.i_ip_read_en = 1'b0;
    check("b2b_ack1", 64'(bus.o_ip_ack), 64'(1));
    check("b2b_rd1", 64'(bus.o_ip_rdata), 64'(m_read(16'h0044)));

    // Reset during a write strobe
    @(negedge i_clk);
    bus.i_ip_address = 16'h0004; bus.i_ip_wdata = 32'hFFFF_FFFF;
    bus.i_ip_write_en = 1'b1; i_reset = 1'b1;
    @(negedge i_clk);
    bus.i_ip_write_en = 1'b0; i_reset = 1'b0;
    m_reset();
    check("rstmid_ack", 64'(bus.o_ip_ack), 64'(0));
    check("rstmid_out", 64'(o_gpio_out), 64'(0));
    check("rstmid_oe", 64'(o_gpio_oe), 64'(40'hFF_FFFF_FFFF));
    rd_exp("rstmid_rd", 16'h0004, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
